// File: rtl/id_ex_alu_issue_pkg.sv
// Shared constants for the ID/EX ALU issue stage.
//   - ALU op select codes driven to the ripple ALU slices
//   - ALUOp class codes produced by the main decoder
//   - R-type funct codes understood by alu_control
//   - Forwarding mux select codes
package id_ex_alu_issue_pkg;

  // ALU op select
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  // ALUOp class
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  // R-type funct
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  // Forwarding select; 2'b11 is reserved and treated as FWD_PIPE
  localparam logic [1:0] FWD_PIPE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/id_ex_alu_issue_alu_control.sv
// ALU control decoder (pure combinational).
// Ports:
//   aluop_i   ALUOp class from the main decoder
//   funct_i   R-type funct field
//   op_o      4-bit ALU op select
//   sub_o     ALU sub / carry-in of bit 0
//   illegal_o the aluop/funct pair is not decodable
module alu_control
  import id_ex_alu_issue_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] op_o,
  output logic       sub_o,
  output logic       illegal_o
);

  always_comb begin
    op_o      = ALU_AND;
    sub_o     = 1'b0;
    illegal_o = 1'b0;
    unique case (aluop_i)
      ALUOP_MEM: begin
        op_o = ALU_ADD;
      end
      ALUOP_BRANCH: begin
        op_o  = ALU_SUB;
        sub_o = 1'b1;
      end
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD, FUNCT_ADDU: op_o = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: begin
            op_o  = ALU_SUB;
            sub_o = 1'b1;
          end
          FUNCT_AND: op_o = ALU_AND;
          FUNCT_OR:  op_o = ALU_OR;
          FUNCT_NOR: op_o = ALU_NOR;
          // SLT subtracts and takes the sign, so it needs carry-in too
          FUNCT_SLT: begin
            op_o  = ALU_SLT;
            sub_o = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register feeding the ripple ALU.
// Registers decoded control and operands, translates ALUOp/funct into the ALU
// op select, and applies EX-stage forwarding after the register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall, flush        hazard control (flush wins over stall)
//   id_*                decoded instruction from the ID stage
//   fwd_a_sel/fwd_b_sel forwarding selects (00 pipe, 01 EX/MEM, 10 MEM/WB, 11 pipe)
//   exmem/memwb_result  forwarded values, used in the same cycle
//   ex_*                EX-stage view presented to the ALU
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        id_aluop,
  input  logic [5:0]        id_funct,
  input  logic [WIDTH-1:0]  id_rs_data,
  input  logic [WIDTH-1:0]  id_rt_data,
  input  logic [WIDTH-1:0]  id_imm,
  input  logic              id_alu_src,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [WIDTH-1:0]  exmem_result,
  input  logic [WIDTH-1:0]  memwb_result,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic              ex_sub,
  output logic [WIDTH-1:0]  ex_a,
  output logic [WIDTH-1:0]  ex_b,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  logic [3:0] dec_op;
  logic       dec_sub;
  logic       dec_illegal;

  alu_control u_alu_control (
    .aluop_i   (id_aluop),
    .funct_i   (id_funct),
    .op_o      (dec_op),
    .sub_o     (dec_sub),
    .illegal_o (dec_illegal)
  );

  logic              valid_q,     valid_d;
  logic [3:0]        op_q,        op_d;
  logic              sub_q,       sub_d;
  logic [WIDTH-1:0]  rs_q,        rs_d;
  logic [WIDTH-1:0]  rt_q,        rt_d;
  logic [WIDTH-1:0]  imm_q,       imm_d;
  logic              alu_src_q,   alu_src_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic              reg_write_q, reg_write_d;
  logic              illegal_q,   illegal_d;

  always_comb begin
    valid_d     = valid_q;
    op_d        = op_q;
    sub_d       = sub_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    if (flush) begin
      valid_d     = 1'b0;
      op_d        = '0;
      sub_d       = 1'b0;
      rs_d        = '0;
      rt_d        = '0;
      imm_d       = '0;
      alu_src_d   = 1'b0;
      rd_d        = '0;
      reg_write_d = 1'b0;
      illegal_d   = 1'b0;
    end else if (!stall) begin
      valid_d     = id_valid;
      op_d        = dec_op;
      sub_d       = dec_sub;
      rs_d        = id_rs_data;
      rt_d        = id_rt_data;
      imm_d       = id_imm;
      alu_src_d   = id_alu_src;
      rd_d        = id_rd;
      // An undecodable op must never commit a register write
      reg_write_d = id_reg_write & id_valid & ~dec_illegal;
      // Bubbles never report illegal
      illegal_d   = dec_illegal & id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      op_q        <= '0;
      sub_q       <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      op_q        <= op_d;
      sub_q       <= sub_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  // Forwarding is applied after the register so late EX/MEM and MEM/WB
  // results reach the ALU in the same cycle.
  logic [WIDTH-1:0] fwd_b_val;

  always_comb begin
    case (fwd_a_sel)
      FWD_EXMEM: ex_a = exmem_result;
      FWD_MEMWB: ex_a = memwb_result;
      default:   ex_a = rs_q;
    endcase
    case (fwd_b_sel)
      FWD_EXMEM: fwd_b_val = exmem_result;
      FWD_MEMWB: fwd_b_val = memwb_result;
      default:   fwd_b_val = rt_q;
    endcase
    // The immediate overrides forwarding: b never reads rt in that case
    ex_b = alu_src_q ? imm_q : fwd_b_val;
  end

  assign ex_valid     = valid_q;
  assign ex_op        = op_q;
  assign ex_sub       = sub_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q;
  assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: a decode vector table plus directed
// sequences for reset, stall/flush, forwarding and immediate selection.
module tb_id_ex_alu_issue;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, flush;
  logic              id_valid;
  logic [1:0]        id_aluop;
  logic [5:0]        id_funct;
  logic [WIDTH-1:0]  id_rs_data, id_rt_data, id_imm;
  logic              id_alu_src;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic [WIDTH-1:0]  exmem_result, memwb_result;
  logic              ex_valid;
  logic [3:0]        ex_op;
  logic              ex_sub;
  logic [WIDTH-1:0]  ex_a, ex_b;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_illegal;

  id_ex_alu_issue #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_aluop     (id_aluop),
    .id_funct     (id_funct),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_imm       (id_imm),
    .id_alu_src   (id_alu_src),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .exmem_result (exmem_result),
    .memwb_result (memwb_result),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_sub       (ex_sub),
    .ex_a         (ex_a),
    .ex_b         (ex_b),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_illegal   (ex_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture on the next rising edge, then sample just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       valid;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic       reg_write;
    logic [3:0] exp_op;
    logic       exp_sub;
    logic       exp_illegal;
    logic       exp_reg_write;
  } dec_vec_t;

  dec_vec_t vecs[14];

  initial begin
    // valid aluop funct rw | op sub ill rw
    vecs[0]  = '{1'b1, 2'b10, 6'b100100, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 2'b10, 6'b100101, 1'b1, 4'd1,  1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 2'b10, 6'b100000, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 2'b10, 6'b100010, 1'b1, 4'd6,  1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 2'b10, 6'b101010, 1'b1, 4'd7,  1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 2'b10, 6'b100111, 1'b1, 4'd12, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 2'b10, 6'b000000, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'b10, 6'b100001, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 2'b10, 6'b100011, 1'b0, 4'd6,  1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 2'b00, 6'b101010, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 2'b01, 6'b100101, 1'b0, 4'd6,  1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 2'b11, 6'b100000, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'b11, 6'b000000, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'b10, 6'b100010, 1'b1, 4'd6,  1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_aluop = 2'b00; id_funct = 6'd0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_alu_src = 1'b0;
    id_rd = '0; id_reg_write = 1'b0;
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    exmem_result = '0; memwb_result = '0;

    // Reset state
    #3;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_op", {28'd0, ex_op}, 32'd0);
    chk("rst_a", ex_a, 32'd0);
    chk("rst_b", ex_b, 32'd0);
    chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("rst_ill", {31'd0, ex_illegal}, 32'd0);

    // Load an ADD
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = 1'b1; id_aluop = 2'b10; id_funct = 6'b100000;
    id_rs_data = 32'h5; id_rt_data = 32'h7; id_rd = 5'd3; id_reg_write = 1'b1;
    step();
    chk("add_op", {28'd0, ex_op}, 32'd2);
    chk("add_a", ex_a, 32'h5);
    chk("add_b", ex_b, 32'h7);
    chk("add_rd", {27'd0, ex_rd}, 32'd3);
    chk("add_valid", {31'd0, ex_valid}, 32'd1);

    // Asynchronous reset between edges clears immediately
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("amid_valid", {31'd0, ex_valid}, 32'd0);
    chk("amid_op", {28'd0, ex_op}, 32'd0);
    chk("amid_a", ex_a, 32'd0);
    chk("amid_rw", {31'd0, ex_reg_write}, 32'd0);
    id_aluop = 2'b01; id_rs_data = 32'h9; id_rd = 5'd4;
    @(negedge clk);
    chk("rsthold_valid", {31'd0, ex_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_op", {28'd0, ex_op}, 32'd6);
    chk("rel_sub", {31'd0, ex_sub}, 32'd1);
    chk("rel_a", ex_a, 32'h9);
    chk("rel_rd", {27'd0, ex_rd}, 32'd4);

    // Decode table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      id_valid = vecs[i].valid; id_aluop = vecs[i].aluop;
      id_funct = vecs[i].funct; id_reg_write = vecs[i].reg_write;
      step();
      chk($sformatf("dec%0d_op", i), {28'd0, ex_op}, {28'd0, vecs[i].exp_op});
      chk($sformatf("dec%0d_sub", i), {31'd0, ex_sub}, {31'd0, vecs[i].exp_sub});
      chk($sformatf("dec%0d_ill", i), {31'd0, ex_illegal}, {31'd0, vecs[i].exp_illegal});
      chk($sformatf("dec%0d_rw", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].exp_reg_write});
      chk($sformatf("dec%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].valid});
    end

    // Stall holds for 3 cycles while ID changes
    @(negedge clk);
    id_valid = 1'b1; id_aluop = 2'b10; id_funct = 6'b100100; id_reg_write = 1'b1;
    id_rs_data = 32'hA; id_rt_data = 32'hB; id_rd = 5'd7;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      id_funct = 6'b100010; id_rs_data = 32'h100 + i; id_rd = 5'd1; id_valid = i[0];
      step();
      chk($sformatf("stall%0d_op", i), {28'd0, ex_op}, 32'd0);
      chk($sformatf("stall%0d_a", i), ex_a, 32'hA);
      chk($sformatf("stall%0d_rd", i), {27'd0, ex_rd}, 32'd7);
      chk($sformatf("stall%0d_valid", i), {31'd0, ex_valid}, 32'd1);
    end
    // flush beats stall; load a non-zero op first so the bubble is visible
    @(negedge clk);
    stall = 1'b0; id_valid = 1'b1; id_funct = 6'b101010;
    step();
    chk("preflush_op", {28'd0, ex_op}, 32'd7);
    @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_op", {28'd0, ex_op}, 32'd0);
    chk("flush_sub", {31'd0, ex_sub}, 32'd0);
    chk("flush_a", ex_a, 32'd0);
    chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);

    // Forwarding on a
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    id_valid = 1'b1; id_aluop = 2'b10; id_funct = 6'b100000;
    id_rs_data = 32'h11; id_rt_data = 32'h55;
    exmem_result = 32'h22; memwb_result = 32'h33;
    step();
    for (int s = 0; s < 4; s++) begin
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      @(negedge clk);
      fwd_a_sel = s[1:0];
      fwd_b_sel = s[1:0];
      #1;
      exp_a = (s == 1) ? 32'h22 : (s == 2) ? 32'h33 : 32'h11;
      exp_b = (s == 1) ? 32'h22 : (s == 2) ? 32'h33 : 32'h55;
      chk($sformatf("fwd_a_sel%0d", s), ex_a, exp_a);
      chk($sformatf("fwd_b_sel%0d", s), ex_b, exp_b);
    end
    // Forward value change propagates without an edge
    @(negedge clk);
    fwd_a_sel = 2'b01; fwd_b_sel = 2'b10;
    #1;
    exmem_result = 32'h44; memwb_result = 32'h66;
    #1;
    chk("fwd_a_live", ex_a, 32'h44);
    chk("fwd_b_live", ex_b, 32'h66);

    // Immediate overrides forwarding on b
    @(negedge clk);
    fwd_b_sel = 2'b01; id_alu_src = 1'b1; id_imm = 32'hFFFFFFFC; id_aluop = 2'b00;
    step();
    chk("imm_b", ex_b, 32'hFFFFFFFC);
    chk("imm_op", {28'd0, ex_op}, 32'd2);
    chk("imm_sub", {31'd0, ex_sub}, 32'd0);

    // Bubble purity
    @(negedge clk);
    id_valid = 1'b0; id_aluop = 2'b11; id_reg_write = 1'b1; id_alu_src = 1'b0;
    step();
    chk("bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("bub_ill", {31'd0, ex_illegal}, 32'd0);
    chk("bub_rw", {31'd0, ex_reg_write}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
- ID/EX pipeline stage directly upstream of the ripple ALU built from one_bit_alu slices.
- Registers decoded operands and control on each clock.
- Translates the ALUOp class and the R-type funct field into the ALU's 4-bit op select and its sub/carry-in control.
- Applies EX-stage forwarding so the ALU receives final a/b operands.

Parameters:
- WIDTH, 32, datapath width in bits (number of ALU slices fed).
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold the current EX contents (hazard unit).
- flush  in  1  replace the next EX contents with a bubble.
- id_valid  in  1  the ID stage holds a real instruction.
- id_aluop  in  2  ALUOp class: 00 mem/addi, 01 branch compare, 10 R-type, 11 reserved.
- id_funct  in  6  R-type funct field.
- id_rs_data  in  WIDTH  register rs value.
- id_rt_data  in  WIDTH  register rt value.
- id_imm  in  WIDTH  sign-extended immediate.
- id_alu_src  in  1  1 selects the immediate as operand b.
- id_rd  in  REG_AW  destination register.
- id_reg_write  in  1  the instruction writes the register file.
- fwd_a_sel  in  2  operand a source: 00 pipeline, 01 EX/MEM, 10 MEM/WB, 11 pipeline.
- fwd_b_sel  in  2  operand b source, same encoding as fwd_a_sel; applies only when ex_alu_src=0.
- exmem_result  in  WIDTH  EX/MEM forward value.
- memwb_result  in  WIDTH  MEM/WB forward value.
- ex_valid  out  1  the EX stage holds a real instruction.
- ex_op  out  4  ALU op select.
- ex_sub  out  1  ALU sub / carry-in of bit 0.
- ex_a  out  WIDTH  final operand a.
- ex_b  out  WIDTH  final operand b.
- ex_rd  out  REG_AW  destination register.
- ex_reg_write  out  1  qualified write enable.
- ex_illegal  out  1  the op was not decodable.

Behaviour:
- Registered state: valid, op, sub, rs, rt, imm, alu_src, rd, reg_write, illegal.
- Reset (rst_n=0, asynchronous): every register is cleared to 0. Outputs then show ex_valid=0, ex_op=0 (AND), ex_sub=0, ex_a=ex_b=0, ex_rd=0, ex_reg_write=0, ex_illegal=0.
- Deasserting reset mid-pipeline discards any in-flight ID instruction. The first capture happens on the first rising edge with rst_n=1.
- Priority per edge: flush > stall > load.
  - flush=1: bubble is loaded (all registers 0), regardless of stall.
  - stall=1, flush=0: all registers hold.
  - Otherwise: ID values are captured. valid <= id_valid; reg_write <= id_reg_write & id_valid & ~illegal_decode.
- Latency: ID inputs are visible on the ex_* outputs one cycle after capture.
- Decode (combinational on ID inputs, result registered):
  - aluop 00 -> op 2 (ADD), sub 0.
  - aluop 01 -> op 6 (SUB), sub 1.
  - aluop 10: funct 100000 or 100001 -> 2/0.
  - aluop 10: funct 100010 or 100011 -> 6/1.
  - aluop 10: funct 100100 -> 0/0 (AND).
  - aluop 10: funct 100101 -> 1/0 (OR).
  - aluop 10: funct 100111 -> 12/0 (NOR).
  - aluop 10: funct 101010 -> 7/1 (SLT).
  - aluop 10, any other funct, and aluop 11: op 0, sub 0, illegal_decode 1.
  - illegal is only registered when id_valid=1. A bubble never reports illegal.
- Operand path (combinational after the register; forward inputs are sampled in the same cycle):
  - ex_a = fwd_a_sel 01 ? exmem_result : fwd_a_sel 10 ? memwb_result : rs_q.
  - ex_b = alu_src_q ? imm_q : (fwd_b_sel mux over rt_q, identical encoding).
  - fwd select 11 is reserved and behaves as 00.
- No arithmetic in this block; widths pass through unchanged.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12.
  - ALUOp class constants.
  - funct constants.
  - forward-select constants.
- One sub-module: alu_control (pure combinational; aluop and funct in, op/sub/illegal out). It is reused by the verification reference model.

Test Plan:
- Reset mid-stream: load an ADD, assert rst_n=0 between edges -> all outputs 0 immediately; the first edge after release captures the current ID inputs.
- Decode sweep, id_valid=1, aluop=10: funct 100100, 100101, 100000, 100010, 101010, 100111 -> ex_op 0, 1, 2, 6, 7, 12 with ex_sub 0, 0, 0, 1, 1, 0 one cycle later. funct 000000 -> ex_illegal=1, ex_reg_write=0.
- Stall/flush: stall=1 for 3 cycles while ID changes -> ex_* constant. stall=1 with flush=1 -> bubble (ex_valid=0, ex_op=0).
- Forwarding: rs=0x11, exmem_result=0x22, memwb_result=0x33. fwd_a_sel=00/01/10/11 -> ex_a=0x11/0x22/0x33/0x11. Change exmem_result in the same cycle -> ex_a follows without waiting an edge.
- Immediate priority: alu_src=1, imm=0xFFFFFFFC, fwd_b_sel=01 -> ex_b=0xFFFFFFFC. aluop=00 -> ex_op=2.
- Bubble purity: id_valid=0, aluop=11 -> ex_valid=0, ex_illegal=0, ex_reg_write=0.
